// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// FSM state encodings and backing-bus opcode values.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE  = 2'd0,
    DMEM_FILL  = 2'd1,
    DMEM_WRITE = 2'd2,
    DMEM_DONE  = 2'd3
  } dmem_state_e;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline-side port plus backing-bus port of the data-memory responder.
// slave: the responder's view; master: the pipeline/backing-memory view.
interface dmem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              mem_stall;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
    output mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, bus_ack, bus_rdata,
    input  mem_din, mem_stall, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dmem_responder_line_store.sv
// Direct-mapped line storage: valid bits, tags and one data word per line.
// Combinational read port, one synchronous write port, synchronous clear of
// all valid bits. Tag/data arrays carry no reset; valid gates them.
module dmem_responder_line_store #(
  parameter int LINES  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear_all_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic              rvalid_o,
  output logic [TAG_W-1:0]  rtag_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Valid vector: clear wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (clear_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: written only when the line is being installed/updated.
  always_ff @(posedge clk) begin
    if (we_i && !clear_all_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: direct-mapped, write-through,
// no-write-allocate cache in front of a req/ack backing bus.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  dmem_state_e       state_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_rd_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic [ADDR_W-1:0] req_addr_word;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              ack_ok;

  logic              st_we;
  logic [IDX_W-1:0]  st_idx;
  logic [TAG_W-1:0]  st_tag;
  logic [DATA_W-1:0] st_data;

  logic              unused_addr_bits;

  assign req_idx       = bus.mem_addr[IDX_W+1:2];
  assign req_tag       = bus.mem_addr[ADDR_W-1:IDX_W+2];
  assign req_addr_word = {bus.mem_addr[ADDR_W-1:2], 2'b00};
  assign fill_idx      = bus_addr_q[IDX_W+1:2];
  assign fill_tag      = bus_addr_q[ADDR_W-1:IDX_W+2];
  assign hit           = line_valid && (line_tag == req_tag);
  // An ack only counts while our own request is on the bus.
  assign ack_ok        = bus.bus_ack && bus_req_q;
  assign unused_addr_bits = ^bus.mem_addr[1:0];

  dmem_responder_line_store #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_line_store (
    .clk         (clk),
    .clear_all_i (rst),
    .we_i        (st_we),
    .widx_i      (st_idx),
    .wtag_i      (st_tag),
    .wdata_i     (st_data),
    .ridx_i      (req_idx),
    .rvalid_o    (line_valid),
    .rtag_o      (line_tag),
    .rdata_o     (line_data)
  );

  // Line-store write port: write-hit update from IDLE, line install on fill ack.
  always_comb begin
    st_we   = 1'b0;
    st_idx  = req_idx;
    st_tag  = req_tag;
    st_data = bus.mem_dout;
    if (!rst) begin
      case (state_q)
        DMEM_IDLE: begin
          if (bus.mem_wen && hit) st_we = 1'b1;
        end
        DMEM_FILL: begin
          if (ack_ok) begin
            st_we   = 1'b1;
            st_idx  = fill_idx;
            st_tag  = fill_tag;
            st_data = bus.bus_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered bus outputs and latched fill data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DMEM_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= BUS_RD;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      done_rd_q   <= 1'b0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          if (bus.mem_wen) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= BUS_WR;
            bus_addr_q  <= req_addr_word;
            bus_wdata_q <= bus.mem_dout;
            done_rd_q   <= 1'b0;
            state_q     <= DMEM_WRITE;
          end else if (bus.mem_ren && !hit) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= BUS_RD;
            bus_addr_q  <= req_addr_word;
            done_rd_q   <= 1'b1;
            state_q     <= DMEM_FILL;
          end
        end
        DMEM_FILL: begin
          if (ack_ok) begin
            bus_req_q <= 1'b0;
            rdata_q   <= bus.bus_rdata;
            state_q   <= DMEM_DONE;
          end
        end
        DMEM_WRITE: begin
          if (ack_ok) begin
            bus_req_q <= 1'b0;
            state_q   <= DMEM_DONE;
          end
        end
        // One release cycle so the still-presented request is not re-issued.
        DMEM_DONE: state_q <= DMEM_IDLE;
        default:   state_q <= DMEM_IDLE;
      endcase
    end
  end

  // Stall and load data: decoded from state, request and hit only.
  always_comb begin
    bus.mem_stall = 1'b0;
    bus.mem_din   = '0;
    if (!rst) begin
      case (state_q)
        DMEM_IDLE: begin
          if (bus.mem_wen) begin
            bus.mem_stall = 1'b1;
          end else if (bus.mem_ren) begin
            if (hit) bus.mem_din   = line_data;
            else     bus.mem_stall = 1'b1;
          end
        end
        DMEM_FILL, DMEM_WRITE: bus.mem_stall = 1'b1;
        DMEM_DONE: begin
          if (done_rd_q) bus.mem_din = rdata_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM-stage port of the 5-stage MIPS datapath: consumes mem_ren/mem_wen/mem_addr/mem_dout and returns mem_din plus a pipeline stall.
- Contains a small direct-mapped, one-word-per-line, write-through, no-write-allocate cache.
- Fronts a slower backing-memory bus with a req/ack handshake.
- mem_stall feeds the pipeline controller, which holds all stage enables while it is high.

Parameters:
- LINES, 16, number of cache lines (power of two, >=2); IDX_W = log2(LINES).
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- mem_ren  in  1  read request from MEM stage.
- mem_wen  in  1  write request from MEM stage.
- mem_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- mem_dout  in  DATA_W  store data from datapath.
- mem_din  out  DATA_W  load data to datapath.
- mem_stall  out  1  hold pipeline; request must stay stable while high.
- bus_req  out  1  backing-bus request, registered.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  word-aligned address, {mem_addr[31:2], 2'b00}.
- bus_wdata  out  DATA_W  write data.
- bus_ack  in  1  one-cycle completion pulse.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.

Behaviour:
- Address split:
  - idx = mem_addr[IDX_W+1:2]
  - tag = mem_addr[ADDR_W-1:IDX_W+2]
  - hit = valid[idx] & (tag_arr[idx] == tag)
- Reset (synchronous):
  - state=IDLE; all valid bits cleared in one cycle.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0; internal data register = 0.
  - mem_stall=0 and mem_din=0 while rst is high.
  - Reset mid-FILL or mid-WRITE abandons the transfer; bus_req is low the cycle after rst. A later bus_ack is ignored. No line is written.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - mem_wen: stall=1; register bus_we=1, addr, wdata; bus_req=1 next cycle; go WRITE.
    - On hit, the line data is updated with mem_dout on the same edge.
    - On miss, no allocate.
  - mem_ren & hit: stall=0 this cycle; mem_din = data_arr[idx] combinationally; stay IDLE. No bus activity.
  - mem_ren & miss: stall=1; register read request; go FILL.
  - mem_ren & mem_wen together: treated as a write.
  - No request: stall=0, mem_din=0.
- FILL:
  - stall=1; bus_req held with stable outputs.
  - On bus_ack: write valid/tag/data for idx, latch bus_rdata, bus_req=0 next cycle, go DONE.
- WRITE:
  - stall=1; bus_req held.
  - On bus_ack: bus_req=0 next cycle, go DONE.
- DONE:
  - Lasts exactly 1 cycle; stall=0; mem_din = latched fill data (read) or 0 (write).
  - The pipeline advances on this cycle; always return to IDLE. This prevents re-issuing the still-presented request.
- Latency:
  - Read hit: 0 extra cycles.
  - Read miss or write: stall from request cycle through ack cycle; DONE is the cycle after ack.
- Bus rules:
  - bus_req/bus_we/bus_addr/bus_wdata are registered and stable from assertion until bus_ack.
  - bus_ack is honoured only in FILL/WRITE, and no earlier than the first cycle bus_req is high.
- mem_stall is combinational from state, request and hit. It never depends on bus_ack in the same cycle.

Decomposition:
- Shared package (mips_define): state encodings DMEM_IDLE/FILL/WRITE/DONE, and bus opcode constants BUS_RD/BUS_WR.
- One sub-module: dmem_line_store.
  - Holds the valid vector, tag and data arrays.
  - Combinational read port (idx → valid, tag, data).
  - One synchronous write port (we, idx, tag, data).
  - Synchronous clear_all input.
- FSM and handshake stay in dmem_responder.

Test Plan:
- Reset, then read 0x40: stall=1, bus_req with bus_addr=0x40 and bus_we=0. bus_ack with 0xDEADBEEF 3 cycles later → next cycle stall=0, mem_din=0xDEADBEEF.
- Read 0x40 again: stall=0 in the same cycle, mem_din=0xDEADBEEF, bus_req stays 0.
- Write 0x40 with 0x12345678: stall until ack, bus_we=1, bus_wdata=0x12345678. Then read 0x40 hits with 0x12345678 and no bus_req.
- Conflict (LINES=16): read 0x80 (idx 0, different tag) misses and fills 0xCAFEF00D. Then read 0x40 misses again.
- Write miss to 0x100, then read 0x100: the read misses (no-allocate) and issues bus_req with bus_addr=0x100.
- Assert rst during FILL: bus_req=0 next cycle, a late bus_ack is ignored, stall=0. A following read of 0x40 misses.
